fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter HALT_OPCODE, default 4'hF, is the opcode in instruction bits [7:4] that halts fetching.
REQ-002 Parameter RESET_PC, default 8'h00, is the PC value loaded on reset.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 start  input  1  is a begin/resume request, honoured only in IDLE and HALT.
REQ-006 imem_addr  output  8  drives the instruction memory address, combinationally.
REQ-007 imem_data  input  8  is the instruction memory read data, combinational from imem_addr.
REQ-008 ir_out  output  8  is the registered instruction presented to the decoder.
REQ-009 ir_valid  output  1  means ir_out holds an unconsumed instruction.
REQ-010 ir_ready  input  1  means the decoder accepts ir_out this cycle.
REQ-011 branch_en  input  1  requests redirect of the next fetch.
REQ-012 branch_target  input  8  is the redirect address.
REQ-013 dbg_req  input  1  is a debug read request for the memory port.
REQ-014 dbg_addr  input  8  is the debug read address.
REQ-015 dbg_data  output  8  is the registered debug read data.
REQ-016 dbg_ack  output  1  is a one-cycle strobe qualifying dbg_data.
REQ-017 pc_out  output  8  is the current PC register.
REQ-018 halted  output  1  is high while in the HALT state.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, FETCH, HOLD and HALT.
REQ-020 IDLE SHALL go to FETCH on start=1 and otherwise remain in IDLE.
REQ-021 In FETCH, imem_addr SHALL equal pc.
REQ-022 At the end of FETCH: IR <= imem_data, ir_valid <= 1, pc <= pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-023 From FETCH, the next state SHALL be HALT if imem_data[7:4]==HALT_OPCODE, else HOLD.
REQ-024 FETCH SHALL last exactly one cycle, giving a latency of 1 clock from entering FETCH to ir_valid=1.
REQ-025 In HOLD, ir_out and ir_valid SHALL stay stable until ir_ready=1.
REQ-026 On the HOLD cycle with ir_ready=1, the block SHALL clear ir_valid and go to FETCH.
  - If branch_en=1 in that same cycle, pc <= branch_target.
REQ-027 branch_en SHALL be ignored in every cycle except a HOLD cycle with ir_ready=1.
REQ-028 ir_ready SHALL be ignored while ir_valid=0.
REQ-029 In HALT, the halting instruction SHALL remain valid until consumed via ir_ready, and no further fetch SHALL occur.
REQ-030 In HALT, branch_en with ir_ready SHALL still load pc <= branch_target.
REQ-031 HALT SHALL go to FETCH on start=1, resuming at the current pc.
  - start and ir_ready in the same cycle: consume first, then fetch.
  - start while ir_valid=1 without ir_ready: ir_valid drops (instruction discarded).
REQ-032 start SHALL be ignored in FETCH and HOLD.
REQ-033 Fetch SHALL have absolute priority on the memory port: a debug grant occurs in any cycle where state != FETCH and dbg_req=1.
REQ-034 In a grant cycle, imem_addr SHALL equal dbg_addr; on the next edge dbg_data <= imem_data and dbg_ack <= 1 for exactly one cycle.
REQ-035 While dbg_req is held high, the block SHALL grant in every non-FETCH cycle.
REQ-036 When state is not FETCH and there is no grant, imem_addr SHALL equal pc.
REQ-037 A debug access SHALL never modify pc, IR, ir_valid or the FSM state.
REQ-038 pc_out SHALL equal the pc register; halted SHALL be combinational from state==HALT.

Reset
REQ-039 rst_n=0 SHALL immediately, and in any state, force: state=IDLE, pc=RESET_PC, IR=8'h00, ir_valid=0, dbg_data=8'h00, dbg_ack=0.
REQ-040 Reset mid-fetch or mid-debug SHALL drop the in-flight access, with no ack issued.
REQ-041 After rst_n rises, the block SHALL stay in IDLE until start.

Verification
REQ-042 Preload mem[0..2]=8'h12,8'h34,8'hF0; start pulse, ir_ready=1 held -> ir_out 12,34,F0 each with 1-cycle valid, halted=1, pc_out=8'h03.
REQ-043 mem[5]=8'hA1, in HOLD with ir_ready=1, branch_en=1, branch_target=8'h05 -> next ir_out=8'hA1, pc_out=8'h06.
REQ-044 pc=8'hFF, mem[FF]=8'h11, mem[00]=8'h22 -> fetches 11 then 22; pc_out wraps 8'h00 -> 8'h01.
REQ-045 dbg_req=1, dbg_addr=8'h40, mem[40]=8'h5A held during HOLD -> dbg_ack next cycle with dbg_data=8'h5A; no grant in FETCH cycles; ir stream unchanged.
REQ-046 ir_ready=0 for 5 cycles in HOLD -> ir_out and ir_valid stable, pc not advanced; branch_en during the stall is ignored.
REQ-047 rst_n asserted asynchronously mid-HOLD with a pending dbg_req -> all outputs at reset values before the next edge; no dbg_ack; IDLE until start.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetches instructions into a single IR and shares the memory port with a debug reader.
// Latency: IR valid one cycle after FETCH; debug data one cycle after the grant.
// Backpressure: IR held until ir_ready; fetch always has priority over debug access.
module fetch_controller #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter logic [7:0] RESET_PC    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] ir_out,
    output logic       ir_valid,
    input  logic       ir_ready,
    input  logic       branch_en,
    input  logic [7:0] branch_target,
    input  logic       dbg_req,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       dbg_ack,
    output logic [7:0] pc_out,
    output logic       halted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0] state, state_nxt;
    logic [7:0] pc, pc_nxt;
    logic [7:0] ir, ir_nxt;
    logic       ir_vld, ir_vld_nxt;
    logic       dbg_gnt;
    logic       consume;

    // Debug only borrows the port in cycles the fetch path leaves it free.
    assign dbg_gnt   = dbg_req && (state != ST_FETCH);
    assign imem_addr = dbg_gnt ? dbg_addr : pc;
    assign consume   = ir_vld && ir_ready;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        ir_vld_nxt = ir_vld;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                ir_nxt     = imem_data;
                ir_vld_nxt = 1'b1;
                pc_nxt     = pc + 8'd1;
                state_nxt  = (imem_data[7:4] == HALT_OPCODE) ? ST_HALT : ST_HOLD;
            end
            ST_HOLD: begin
                if (consume) begin
                    ir_vld_nxt = 1'b0;
                    state_nxt  = ST_FETCH;
                    if (branch_en) pc_nxt = branch_target;
                end
            end
            ST_HALT: begin
                if (consume) begin
                    ir_vld_nxt = 1'b0;
                    if (branch_en) pc_nxt = branch_target;
                end
                // Resuming discards a halting instruction nobody consumed.
                if (start) begin
                    ir_vld_nxt = 1'b0;
                    state_nxt  = ST_FETCH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            ir     <= 8'h00;
            ir_vld <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            ir_vld <= ir_vld_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= 8'h00;
            dbg_ack  <= 1'b0;
        end else begin
            dbg_ack <= dbg_gnt;
            if (dbg_gnt) dbg_data <= imem_data;
        end
    end

    assign ir_out   = ir;
    assign ir_valid = ir_vld;
    assign pc_out   = pc;
    assign halted   = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed scenarios plus random traffic, checked every cycle against a rule-level model.
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       ir_ready = 1'b0;
    logic       branch_en = 1'b0;
    logic       dbg_req = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] imem_addr, imem_data, ir_out, dbg_data, pc_out;
    logic       ir_valid, dbg_ack, halted;

    logic [7:0] mem [256];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .branch_en(branch_en), .branch_target(branch_target),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .pc_out(pc_out), .halted(halted)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: started = left IDLE since reset, fetch_due = this cycle reads the IR.
    logic [7:0] m_pc, m_ir, m_dbg_data;
    logic       m_valid, m_halted, m_fetch_due, m_started, m_dbg_ack;
    logic [7:0] seen [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_ir = 8'h00; m_dbg_data = 8'h00;
        m_valid = 1'b0; m_halted = 1'b0; m_fetch_due = 1'b0;
        m_started = 1'b0; m_dbg_ack = 1'b0;
    endtask

    task automatic check_outputs(input string ph);
        logic [7:0] exp_addr;
        exp_addr = (!m_fetch_due && dbg_req) ? dbg_addr : m_pc;
        check({ph, ".ir_valid"}, ir_valid, m_valid);
        check({ph, ".ir_out"}, ir_out, m_ir);
        check({ph, ".pc_out"}, pc_out, m_pc);
        check({ph, ".halted"}, halted, m_halted);
        check({ph, ".imem_addr"}, imem_addr, exp_addr);
        check({ph, ".dbg_ack"}, dbg_ack, m_dbg_ack);
        check({ph, ".dbg_data"}, dbg_data, m_dbg_data);
    endtask

    task automatic model_step();
        logic grant, consume;
        grant = dbg_req && !m_fetch_due;
        m_dbg_ack = grant;
        if (grant) m_dbg_data = mem[dbg_addr];
        if (m_fetch_due) begin
            m_ir = mem[m_pc];
            m_valid = 1'b1;
            m_halted = (m_ir[7:4] == 4'hF);
            m_pc = m_pc + 8'd1;
            m_fetch_due = 1'b0;
        end else begin
            consume = m_valid && ir_ready;
            if (consume) begin
                m_valid = 1'b0;
                if (branch_en) m_pc = branch_target;
            end
            if (!m_started || m_halted) begin
                if (start) begin
                    m_started = 1'b1;
                    m_halted = 1'b0;
                    m_valid = 1'b0;
                    m_fetch_due = 1'b1;
                end
            end else if (consume) begin
                m_fetch_due = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic s, input logic r, input logic b, input logic [7:0] t,
                         input logic d, input logic [7:0] a);
        @(negedge clk);
        start = s; ir_ready = r; branch_en = b; branch_target = t;
        dbg_req = d; dbg_addr = a;
        #1;
        check_outputs("cyc");
        if (ir_valid && ir_ready) seen.push_back(ir_out);
        model_step();
    endtask

    task automatic idle_inputs();
        start = 1'b0; ir_ready = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
        dbg_req = 1'b0; dbg_addr = 8'h00;
    endtask

    task automatic check_reset_values(input string ph);
        check({ph, ".ir_valid"}, ir_valid, 1'b0);
        check({ph, ".ir_out"}, ir_out, 8'h00);
        check({ph, ".pc_out"}, pc_out, 8'h00);
        check({ph, ".halted"}, halted, 1'b0);
        check({ph, ".dbg_ack"}, dbg_ack, 1'b0);
        check({ph, ".dbg_data"}, dbg_data, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hF0;
        mem[3] = 8'h07; mem[5] = 8'hA1; mem[8'hFF] = 8'h11; mem[8'h40] = 8'h5A;
        model_reset();

        #1 rst_n = 1'b0;
        #1 check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with debug traffic: no fetch until start.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'($urandom));

        // Straight-line program ending in a halt.
        seen.delete();
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("seq.count", seen.size(), 3);
        check("seq.ir0", seen[0], 8'h12);
        check("seq.ir1", seen[1], 8'h34);
        check("seq.ir2", seen[2], 8'hF0);
        check("seq.halted", halted, 1'b1);
        check("seq.pc", pc_out, 8'h03);

        mem[0] = 8'h22; mem[1] = 8'hF5; mem[2] = 8'h33;

        // Resume from halt, then branch on consume.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("resume.ir", ir_out, 8'h07);
        cycle(1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Stall with ignored branches.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0, 8'h00);
            check("stall.ir", ir_out, 8'hA1);
            check("stall.vld", ir_valid, 1'b1);
            check("stall.pc", pc_out, 8'h06);
        end

        // PC wrap through 8'hFF.
        cycle(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wrap.ir_ff", ir_out, 8'h11);
        check("wrap.pc_00", pc_out, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wrap.ir_00", ir_out, 8'h22);
        check("wrap.pc_01", pc_out, 8'h01);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("halt2.halted", halted, 1'b1);
        check("halt2.ir", ir_out, 8'hF5);

        // Start discards the unconsumed halt, then debug reads during HOLD.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40);
        check("dbg.ack", dbg_ack, 1'b1);
        check("dbg.data", dbg_data, 8'h5A);
        check("dbg.ir", ir_out, 8'h33);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40);
        check("dbg.fetch_addr", imem_addr, 8'h03);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40);
        check("dbg.no_ack_fetch", dbg_ack, 1'b0);
        check("dbg.ir_next", ir_out, 8'h07);

        // Asynchronous reset mid-HOLD with a debug request pending.
        #1 rst_n = 1'b0;
        #1 check_reset_values("arst");
        model_reset();
        @(negedge clk);
        #1 check("arst.no_ack", dbg_ack, 1'b0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b1, 8'($urandom));
        check("post_rst.vld", ir_valid, 1'b0);
        check("post_rst.pc", pc_out, 8'h00);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
